// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Optional per-requester beat counters are compiled in when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic                      busy
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
    output logic [15:0]                stat_count
`endif
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    owner;
    logic [IDX_W-1:0]    last;
    logic [BEAT_W-1:0]   beats;

    logic [IDX_W-1:0]    pick;
    logic [IDX_W-1:0]    cand;
    logic                pick_found;
    logic                owner_valid;
    logic [DATA_W-1:0]   owner_data;
    logic                burst_done;

    // Search starts just after the previous owner and wraps, so reset (last = NUM_REQ-1)
    // makes requester 0 the first winner.
    always_comb begin
        pick       = last;
        cand       = last;
        pick_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    // Valid/ready: a word transfers on a rising edge where req_valid[i] and req_ready[i]
    // are both high; a producer keeps req_data stable while valid is high and ready is low.
    always_comb begin
        owner_valid  = req_valid[owner];
        owner_data   = req_data[owner*DATA_W +: DATA_W];
        req_ready    = grant & {NUM_REQ{~fifo_full}};
        fifo_wr      = busy & owner_valid & ~fifo_full;
        fifo_data_in = busy ? owner_data : '0;
        burst_done   = fifo_wr && (beats == BEAT_W'(MAX_BURST - 1));
    end

    // busy is the registered image of the GRANT state and doubles as the state probe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            last  <= IDX_W'(NUM_REQ - 1);
            beats <= '0;
            grant <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner <= pick;
                        grant <= NUM_REQ'(1) << pick;
                        beats <= '0;
                        busy  <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (fifo_wr) begin
                        beats <= beats + 1'b1;
                    end
                    // A full FIFO stalls the owner but never ends its burst.
                    if (burst_done || !owner_valid) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        last  <= owner;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] stat_cnt [NUM_REQ];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_cnt[i] <= '0;
            end
            stat_count <= '0;
        end else begin
            if (fifo_wr && (stat_cnt[owner] != 16'hFFFF)) begin
                stat_cnt[owner] <= stat_cnt[owner] + 16'd1;
            end
            stat_count <= (int'(stat_sel) < NUM_REQ) ? stat_cnt[stat_sel] : '0;
        end
    end
`endif

    a_grant_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(grant));
    a_wr_needs_grant: assert property (@(posedge clock) disable iff (reset) fifo_wr |-> busy);
    a_busy_matches_grant: assert property (@(posedge clock) disable iff (reset) busy == (grant != '0));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: randomized producers and FIFO backpressure checked against a
// cycle-level reference model of the arbitration rules plus per-producer ordering scoreboards.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     grant;
  logic              fifo_full = 1'b0;
  logic              fifo_wr;
  logic [DW-1:0]     fifo_data_in;
  logic              busy;
`ifdef FIFO_ARB_STATS_EN
  logic [$clog2(NR)-1:0] stat_sel = '0;
  logic [15:0]           stat_count;
`endif

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .grant(grant),
    .fifo_full(fifo_full),
    .fifo_wr(fifo_wr),
    .fifo_data_in(fifo_data_in),
    .busy(busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_sel(stat_sel),
    .stat_count(stat_count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_vec = 0;
  int n_err = 0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- producer / FIFO drivers ----------------
  logic [DW-1:0] src_q [NR][$];
  logic [DW-1:0] sent  [NR][$];
  bit   [NR-1:0] cur_valid = '0;
  int            gap_pct = 0;
  int            full_pct = 0;
  bit            full_hold = 1'b0;

  typedef struct {
    int            owner;
    logic [DW-1:0] data;
    int            cyc;
  } wr_rec_t;
  wr_rec_t wr_log[$];

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_w;

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() == 0) cur_valid[i] = 1'b0;
      else if (!cur_valid[i]) cur_valid[i] = (gap_pct == 0) || ($urandom_range(0, 99) >= gap_pct);
      req_valid[i] = cur_valid[i];
      req_data[i*DW +: DW] = cur_valid[i] ? src_q[i][0] : DW'($urandom);
    end
    fifo_full = (full_pct > 0) ? ($urandom_range(0, 99) < full_pct) : full_hold;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) begin
      src_q[i].delete();
      sent[i].delete();
    end
    cur_valid = '0;
    gap_pct = 0;
    full_pct = 0;
    full_hold = 1'b0;
    wr_log.delete();
  endtask

  // One clock: note accepted words at the negedge, retire them after the edge, redrive.
  task automatic run_cycles(input int n);
    logic [NR-1:0] acc;
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      acc = req_valid & req_ready;
      @(posedge clock);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          void'(src_q[i].pop_front());
          cur_valid[i] = 1'b0;
        end
      end
      drive_inputs();
      #2;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_all();
    drive_inputs();
    @(negedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive_inputs();
    #2;
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- reference model + monitor ----------------
  // The model tracks who owns the port (-1 = nobody), the previous owner and the beat count,
  // and predicts every output from those plus the live inputs.
  int m_owner = -1;
  int m_last  = NR - 1;
  int m_beats = 0;
  int m_idx;
  bit m_found;
  logic          e_busy, e_wr;
  logic [NR-1:0] e_grant, e_ready;
  logic [DW-1:0] e_data;

  task automatic drain(input int budget);
    int c = 0;
    while ((any_pending() || m_owner >= 0) && c < budget) begin
      run_cycles(1);
      c++;
    end
    n_vec++;
    if (c >= budget) begin
      n_err++;
      $display("FAIL drain_timeout got=%0d cycles required<%0d", c, budget);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      m_owner = -1;
      m_last  = NR - 1;
      m_beats = 0;
    end
    e_busy  = (m_owner >= 0);
    m_idx   = e_busy ? m_owner : 0;
    e_grant = e_busy ? (NR'(1) << m_idx) : '0;
    e_ready = (e_busy && !fifo_full) ? e_grant : '0;
    e_wr    = e_busy && req_valid[m_idx] && !fifo_full;
    e_data  = e_busy ? req_data[m_idx*DW +: DW] : '0;

    n_vec++;
    if (grant !== e_grant) begin
      n_err++;
      $display("FAIL mon_grant cyc=%0d got=%b exp=%b", cyc, grant, e_grant);
    end
    n_vec++;
    if (busy !== e_busy) begin
      n_err++;
      $display("FAIL mon_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy);
    end
    n_vec++;
    if (req_ready !== e_ready) begin
      n_err++;
      $display("FAIL mon_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready);
    end
    n_vec++;
    if (fifo_wr !== e_wr) begin
      n_err++;
      $display("FAIL mon_wr cyc=%0d got=%b exp=%b", cyc, fifo_wr, e_wr);
    end
    n_vec++;
    if (fifo_data_in !== e_data) begin
      n_err++;
      $display("FAIL mon_data cyc=%0d got=%h exp=%h", cyc, fifo_data_in, e_data);
    end

    if (fifo_wr === 1'b1) wr_log.push_back('{owner: m_owner, data: fifo_data_in, cyc: cyc});

    if (!reset) begin
      if (m_owner < 0) begin
        m_found = 1'b0;
        for (int k = 1; k <= NR; k++) begin
          if (!m_found && req_valid[(m_last + k) % NR]) begin
            m_owner = (m_last + k) % NR;
            m_beats = 0;
            m_found = 1'b1;
          end
        end
      end else begin
        if (e_wr) m_beats++;
        if ((e_wr && m_beats == MB) || !req_valid[m_owner]) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    req_valid = '1;
    #1;
    n_vec++;
    if (grant !== '0 || busy !== 1'b0 || req_ready !== '0 || fifo_wr !== 1'b0 || fifo_data_in !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got grant=%b busy=%b ready=%b wr=%b data=%h required all zero",
               grant, busy, req_ready, fifo_wr, fifo_data_in);
    end
    apply_reset();
    n_vec++;
    if (grant !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release got grant=%b busy=%b required 0/0", grant, busy);
    end
  endtask

  task automatic test_single_producer();
    apply_reset();
    src_q[0].push_back(8'h11);
    src_q[0].push_back(8'h22);
    src_q[0].push_back(8'h33);
    drive_inputs();
    #1;
    n_vec++;
    if (grant !== '0) begin
      n_err++;
      $display("FAIL single_pre_grant got=%b required=0000", grant);
    end
    run_cycles(1);
    n_vec++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_grant got=%b busy=%b required=0001 busy=1", grant, busy);
    end
    drain(50);
    n_vec++;
    if (grant !== '0) begin
      n_err++;
      $display("FAIL single_release got=%b required=0000", grant);
    end
    exp_q = '{8'h11, 8'h22, 8'h33};
    n_vec++;
    if (wr_log.size() != 3) begin
      n_err++;
      $display("FAIL single_count got=%0d required=3", wr_log.size());
    end
    foreach (wr_log[k]) begin
      exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_vec++;
      if (wr_log[k].data !== exp_w || wr_log[k].owner != 0) begin
        n_err++;
        $display("FAIL single_data[%0d] got=%h/req%0d required=%h/req0", k, wr_log[k].data, wr_log[k].owner, exp_w);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] words [NR][8];
    apply_reset();
    for (int i = 0; i < NR; i++) begin
      for (int b = 0; b < 8; b++) begin
        words[i][b] = DW'($urandom);
        src_q[i].push_back(words[i][b]);
      end
    end
    exp_q.delete();
    for (int r = 0; r < 8 / MB; r++)
      for (int i = 0; i < NR; i++)
        for (int b = 0; b < MB; b++) exp_q.push_back(words[i][r*MB + b]);
    drive_inputs();
    drain(200);
    n_vec++;
    if (wr_log.size() != NR * 8) begin
      n_err++;
      $display("FAIL rr_count got=%0d required=%0d", wr_log.size(), NR * 8);
    end
    foreach (wr_log[k]) begin
      exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_vec++;
      if (wr_log[k].data !== exp_w || wr_log[k].owner != (k / MB) % NR) begin
        n_err++;
        $display("FAIL rr_order[%0d] got=%h/req%0d required=%h/req%0d",
                 k, wr_log[k].data, wr_log[k].owner, exp_w, (k / MB) % NR);
      end
      if (k > 0) begin
        n_vec++;
        if (wr_log[k].cyc - wr_log[k-1].cyc != ((k % MB == 0) ? 2 : 1)) begin
          n_err++;
          $display("FAIL rr_spacing[%0d] got=%0d required=%0d",
                   k, wr_log[k].cyc - wr_log[k-1].cyc, (k % MB == 0) ? 2 : 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w [6];
    apply_reset();
    for (int b = 0; b < 6; b++) begin
      w[b] = DW'($urandom);
      src_q[0].push_back(w[b]);
    end
    drive_inputs();
    run_cycles(2);
    full_hold = 1'b1;
    drive_inputs();
    #1;
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if (fifo_wr !== 1'b0 || req_ready !== '0 || grant !== 4'b0001) begin
        n_err++;
        $display("FAIL bp_hold[%0d] got wr=%b ready=%b grant=%b required 0/0000/0001", c, fifo_wr, req_ready, grant);
      end
      run_cycles(1);
    end
    full_hold = 1'b0;
    drive_inputs();
    #1;
    n_vec++;
    if (fifo_wr !== 1'b1 || fifo_data_in !== w[1]) begin
      n_err++;
      $display("FAIL bp_resume got wr=%b data=%h required wr=1 data=%h", fifo_wr, fifo_data_in, w[1]);
    end
    n_vec++;
    if (wr_log.size() != 1) begin
      n_err++;
      $display("FAIL bp_no_beats got=%0d required=1", wr_log.size());
    end
    drain(100);
    n_vec++;
    if (wr_log.size() != 6) begin
      n_err++;
      $display("FAIL bp_count got=%0d required=6", wr_log.size());
    end
    foreach (wr_log[k]) begin
      n_vec++;
      if (k < 6 && wr_log[k].data !== w[k]) begin
        n_err++;
        $display("FAIL bp_data[%0d] got=%h required=%h", k, wr_log[k].data, w[k]);
      end
    end
  endtask

  task automatic test_wrap_priority();
    logic [DW-1:0] w1 [2];
    logic [DW-1:0] w3 [2];
    apply_reset();
    src_q[3].push_back(DW'($urandom));
    drive_inputs();
    drain(20);
    wr_log.delete();
    exp_q.delete();
    for (int b = 0; b < 2; b++) begin
      w1[b] = DW'($urandom);
      w3[b] = DW'($urandom);
      src_q[1].push_back(w1[b]);
      src_q[3].push_back(w3[b]);
    end
    exp_q = '{w1[0], w1[1], w3[0], w3[1]};
    drive_inputs();
    run_cycles(1);
    n_vec++;
    if (grant !== 4'b0010) begin
      n_err++;
      $display("FAIL wrap_grant got=%b required=0010", grant);
    end
    drain(50);
    n_vec++;
    if (wr_log.size() != 4) begin
      n_err++;
      $display("FAIL wrap_count got=%0d required=4", wr_log.size());
    end
    foreach (wr_log[k]) begin
      exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_vec++;
      if (wr_log[k].data !== exp_w) begin
        n_err++;
        $display("FAIL wrap_order[%0d] got=%h required=%h", k, wr_log[k].data, exp_w);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int saved;
    apply_reset();
    for (int b = 0; b < 6; b++) src_q[2].push_back(DW'($urandom));
    drive_inputs();
    run_cycles(2);
    n_vec++;
    if (fifo_wr !== 1'b1 || grant !== 4'b0100) begin
      n_err++;
      $display("FAIL rst_pre got wr=%b grant=%b required wr=1 grant=0100", fifo_wr, grant);
    end
    saved = wr_log.size();
    reset = 1'b1;
    #1;
    n_vec++;
    if (grant !== '0 || fifo_wr !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_async got grant=%b wr=%b busy=%b required all zero", grant, fifo_wr, busy);
    end
    clear_all();
    for (int b = 0; b < 2; b++) begin
      src_q[0].push_back(DW'($urandom));
      src_q[2].push_back(DW'($urandom));
    end
    @(negedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive_inputs();
    #1;
    n_vec++;
    if (wr_log.size() != 0 || saved != 1) begin
      n_err++;
      $display("FAIL rst_dropped got log=%0d saved=%0d required 0/1", wr_log.size(), saved);
    end
    run_cycles(1);
    n_vec++;
    if (grant !== 4'b0001) begin
      n_err++;
      $display("FAIL rst_first_winner got=%b required=0001", grant);
    end
    drain(50);
  endtask

  task automatic test_random();
    for (int round = 0; round < 3; round++) begin
      apply_reset();
      gap_pct  = 30;
      full_pct = 25;
      for (int i = 0; i < NR; i++) begin
        int len = $urandom_range(0, 10);
        for (int b = 0; b < len; b++) begin
          logic [DW-1:0] v = DW'($urandom);
          src_q[i].push_back(v);
          sent[i].push_back(v);
        end
      end
      drive_inputs();
      drain(3000);
      for (int i = 0; i < NR; i++) begin
        exp_q = sent[i];
        foreach (wr_log[k]) begin
          if (wr_log[k].owner == i) begin
            exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_vec++;
            if (wr_log[k].data !== exp_w) begin
              n_err++;
              $display("FAIL rand_data r%0d req%0d got=%h required=%h", round, i, wr_log[k].data, exp_w);
            end
          end
        end
        n_vec++;
        if (exp_q.size() != 0) begin
          n_err++;
          $display("FAIL rand_missing r%0d req%0d got=%0d unsent required=0", round, i, exp_q.size());
        end
      end
    end
  endtask

`ifdef FIFO_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    for (int b = 0; b < 7; b++) src_q[2].push_back(DW'($urandom));
    drive_inputs();
    drain(100);
    for (int s = 0; s < NR; s++) begin
      stat_sel = s[$clog2(NR)-1:0];
      run_cycles(1);
      n_vec++;
      if (stat_count !== ((s == 2) ? 16'd7 : 16'd0)) begin
        n_err++;
        $display("FAIL stats_sel%0d got=%0d required=%0d", s, stat_count, (s == 2) ? 7 : 0);
      end
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    clear_all();
    drive_inputs();
    apply_reset();
    test_reset();
    test_single_producer();
    test_round_robin();
    test_backpressure();
    test_wrap_priority();
    test_reset_mid_burst();
    test_random();
`ifdef FIFO_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
